// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the digit-serial add/sub block: control-state
// encodings and default geometry.
package seq_addsub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned WIDTH_DFLT = 16;
  localparam int unsigned DIGIT_DFLT = 4;

endpackage

// File: rtl/add_digit.sv
// Combinational DIGIT-bit ripple adder; cmsb is the carry into the top bit,
// used by the caller for signed-overflow detection.
module add_digit #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] r,
  output logic             co,
  output logic             cmsb
);

  logic [DIGIT:0] cv;

  assign cv[0] = ci;

  // Full-adder chain, one stage per bit.
  for (genvar i = 0; i < int'(DIGIT); i++) begin : g_fa
    assign r[i]    = a[i] ^ b[i] ^ cv[i];
    assign cv[i+1] = (a[i] & b[i]) | (cv[i] & (a[i] ^ b[i]));
  end

  assign co   = cv[DIGIT];
  assign cmsb = cv[DIGIT-1];

endmodule

// File: rtl/seq_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle, LSB digit first,
// WIDTH/DIGIT RUN cycles per operation. Results are published only on the
// edge entering DONE and held until the next completed operation.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DFLT,
  parameter int unsigned DIGIT = DIGIT_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = $clog2(N + 1);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt_q;

  logic [DIGIT-1:0]       dig_r;
  logic                   dig_co;
  logic                   dig_cmsb;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_next;
  logic                   accept;
  logic                   last;

  add_digit #(.DIGIT(DIGIT)) u_add (
    .a    (a_sr[DIGIT-1:0]),
    .b    (b_sr[DIGIT-1:0]),
    .ci   (carry),
    .r    (dig_r),
    .co   (dig_co),
    .cmsb (dig_cmsb)
  );

  // New digit enters the result register from the top.
  assign res_cat  = {dig_r, res_sr};
  assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];

  // start is honoured in IDLE and DONE, never while RUN.
  assign accept = start && (state_q != ST_RUN);
  assign last   = (state_q == ST_RUN) && (cnt_q == CW'(N - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last)  state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath, digit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      r      <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b1;
    end else begin
      busy <= (state_d == ST_RUN);
      done <= (state_d == ST_DONE);
      if (accept) begin
        a_sr   <= a;
        b_sr   <= sub ? ~b : b;
        carry  <= sub;
        cnt_q  <= '0;
        res_sr <= '0;
      end else if (state_q == ST_RUN) begin
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        carry  <= dig_co;
        cnt_q  <= cnt_q + CW'(1);
        res_sr <= res_next;
        if (last) begin
          r    <= res_next;
          co   <= dig_co;
          ovf  <= dig_co ^ dig_cmsb;
          zero <= (res_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_addsub.sv
// Directed bench for seq_addsub at WIDTH=16 with DIGIT = 4, 1 and 16.
module tb_seq_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;

  logic        busy4, done4, co4, ovf4, zero4;
  logic [15:0] r4;
  logic        busy1, done1, co1, ovf1, zero1;
  logic [15:0] r1;
  logic        busy16, done16, co16, ovf16, zero16;
  logic [15:0] r16;

  logic        obs_busy, obs_done, obs_co, obs_ovf, obs_zero;
  logic [15:0] obs_r;
  int          sel;

  int n_chk  = 0;
  int n_pass = 0;

  logic [15:0] va [4];
  logic [15:0] vb [4];
  logic        vs [4];
  logic [15:0] vr [4];
  logic        vc [4];
  logic        vo [4];

  always #5 clk = ~clk;

  seq_addsub #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .r(r4), .co(co4), .ovf(ovf4), .zero(zero4));

  seq_addsub #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .r(r1), .co(co1), .ovf(ovf1), .zero(zero1));

  seq_addsub #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy16), .done(done16), .r(r16), .co(co16), .ovf(ovf16), .zero(zero16));

  // Select which instance the checks observe.
  always_comb begin
    case (sel)
      1: {obs_busy, obs_done, obs_r, obs_co, obs_ovf, obs_zero} = {busy1, done1, r1, co1, ovf1, zero1};
      2: {obs_busy, obs_done, obs_r, obs_co, obs_ovf, obs_zero} = {busy16, done16, r16, co16, ovf16, zero16};
      default: {obs_busy, obs_done, obs_r, obs_co, obs_ovf, obs_zero} = {busy4, done4, r4, co4, ovf4, zero4};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single operation on the DIGIT=4 instance with full handshake checks.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                        input logic [15:0] er, input logic ec, input logic eo,
                        input logic ez, input string tag);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check({tag, "_busy_run"}, 32'(obs_busy), 32'd1);
      check({tag, "_done_run"}, 32'(obs_done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(obs_done), 32'd1);
    check({tag, "_busy_end"}, 32'(obs_busy), 32'd0);
    check({tag, "_r"}, 32'(obs_r), 32'(er));
    check({tag, "_co"}, 32'(obs_co), 32'(ec));
    check({tag, "_ovf"}, 32'(obs_ovf), 32'(eo));
    check({tag, "_zero"}, 32'(obs_zero), 32'(ez));
    tick();
    check({tag, "_done_clr"}, 32'(obs_done), 32'd0);
    check({tag, "_r_hold"}, 32'(obs_r), 32'(er));
  endtask

  // start held high: three results, done every n+1 cycles.
  task automatic b2b(input int s, input int n, input string tag);
    int cyc;
    int i;
    int guard;
    bit upd;
    sel = s;
    do_reset();
    a = va[0]; b = vb[0]; sub = vs[0]; start = 1'b1;
    tick();
    a = va[1]; b = vb[1]; sub = vs[1];
    cyc = 0; i = 0; guard = 0; upd = 1'b0;
    while (i < 3 && guard < 200) begin
      tick();
      cyc++; guard++;
      if (upd) begin
        a = va[i+1]; b = vb[i+1]; sub = vs[i+1];
        upd = 1'b0;
      end
      if (obs_done) begin
        check($sformatf("%s_r%0d", tag, i), 32'(obs_r), 32'(vr[i]));
        check($sformatf("%s_co%0d", tag, i), 32'(obs_co), 32'(vc[i]));
        check($sformatf("%s_ovf%0d", tag, i), 32'(obs_ovf), 32'(vo[i]));
        check($sformatf("%s_gap%0d", tag, i), 32'(cyc), (i == 0) ? 32'(n) : 32'(n + 1));
        cyc = 0;
        i++;
        upd = 1'b1;
      end
    end
    check({tag, "_timeout"}, 32'(i), 32'd3);
    start = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    int pulses;
    va[0] = 16'h1234; vb[0] = 16'h0FFF; vs[0] = 1'b0; vr[0] = 16'h2233; vc[0] = 1'b0; vo[0] = 1'b0;
    va[1] = 16'h0001; vb[1] = 16'h0002; vs[1] = 1'b1; vr[1] = 16'hFFFF; vc[1] = 1'b0; vo[1] = 1'b0;
    va[2] = 16'hFFFF; vb[2] = 16'h0001; vs[2] = 1'b0; vr[2] = 16'h0000; vc[2] = 1'b1; vo[2] = 1'b0;
    va[3] = 16'h7FFF; vb[3] = 16'h0001; vs[3] = 1'b0; vr[3] = 16'h8000; vc[3] = 1'b0; vo[3] = 1'b1;

    sel = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    do_reset();
    check("rst_busy", 32'(obs_busy), 32'd0);
    check("rst_done", 32'(obs_done), 32'd0);
    check("rst_r", 32'(obs_r), 32'd0);
    check("rst_co", 32'(obs_co), 32'd0);
    check("rst_ovf", 32'(obs_ovf), 32'd0);
    check("rst_zero", 32'(obs_zero), 32'd1);

    run_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0, "add");
    run_op(16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, "sub_neg");
    run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, "add_ovf");
    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, "add_wrap");
    run_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, "sub_ovf");
    run_op(16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, "sub_zero");

    // start during RUN must not disturb the operation in flight.
    a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(obs_busy), 32'd1);
    tick();
    check("ign_done", 32'(obs_done), 32'd1);
    check("ign_r", 32'(obs_r), 32'h2233);
    check("ign_co", 32'(obs_co), 32'd0);
    tick();
    check("ign_idle", 32'(obs_busy), 32'd0);

    // Reset in the second RUN cycle aborts with no done pulse.
    a = 16'hFFFF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(obs_busy), 32'd0);
    check("abort_done", 32'(obs_done), 32'd0);
    check("abort_r", 32'(obs_r), 32'd0);
    check("abort_zero", 32'(obs_zero), 32'd1);
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (obs_done) pulses++;
    end
    check("abort_nopulse", 32'(pulses), 32'd0);

    b2b(0, 4, "b2b_d4");
    b2b(1, 16, "b2b_d1");
    b2b(2, 1, "b2b_d16");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
